layer_motion_updater: RTL and testbench



---
 rtl/gpu_layer_pkg.sv | 30 +++
 rtl/layer_motion_calc.sv | 48 ++++
 rtl/layer_motion_updater.sv | 164 ++++++++++++++++
 tb/tb_layer_motion_updater.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_layer_pkg.sv
// rtl/gpu_layer_pkg.sv - layer header register map, flag bit positions and updater FSM states
package gpu_layer_pkg;

  localparam logic [2:0] REG_FLAGS = 3'd0;
  localparam logic [2:0] REG_XPOS  = 3'd3;
  localparam logic [2:0] REG_YPOS  = 3'd4;
  localparam logic [2:0] REG_XVEL  = 3'd5;
  localparam logic [2:0] REG_YVEL  = 3'd6;
  localparam logic [2:0] REG_FRAME = 3'd7;

  localparam int FLAG_POP    = 0;
  localparam int FLAG_SPRITE = 1;
  localparam int FLAG_HIDDEN = 2;
  localparam int FLAG_ANIM   = 3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_FLAGS,
    ST_RD_XPOS,
    ST_RD_YPOS,
    ST_RD_XVEL,
    ST_RD_YVEL,
    ST_RD_FRAME,
    ST_WR_XPOS,
    ST_WR_YPOS,
    ST_WR_FRAME,
    ST_DONE
  } motionStateT;

endpackage

// File: rtl/layer_motion_calc.sv
// rtl/layer_motion_calc.sv - position step and animation frame advance
// LAYER_MOTION_CLAMP_EN makes the position add saturate to int16 instead of wrapping.
module layer_motion_calc #(
  parameter int VEL_SHIFT = 6
) (
  input  logic [15:0] pos,
  input  logic [15:0] vel,
  input  logic [7:0]  cur,
  input  logic [7:0]  count,
  input  logic        animEn,
  output logic [15:0] newPos,
  output logic [7:0]  nextFrame
);

  logic [15:0] disp;
  logic [8:0]  curPlusOne;
`ifdef LAYER_MOTION_CLAMP_EN
  logic [16:0] sum;
`endif

  always_comb begin
    disp = 16'($signed(vel) >>> VEL_SHIFT);
`ifdef LAYER_MOTION_CLAMP_EN
    sum = {pos[15], pos} + {disp[15], disp};
    // bits 16 and 15 disagree only when the signed add left the int16 range
    if (sum[16] != sum[15]) begin
      newPos = sum[16] ? 16'h8000 : 16'h7FFF;
    end else begin
      newPos = sum[15:0];
    end
`else
    newPos = pos + disp;
`endif
  end

  // nine-bit compare so cur=255 does not wrap to 0 before the test
  always_comb begin
    curPlusOne = {1'b0, cur} + 9'd1;
    if (!animEn || count == 8'd0) begin
      nextFrame = cur;
    end else if (curPlusOne >= {1'b0, count}) begin
      nextFrame = 8'd0;
    end else begin
      nextFrame = curPlusOne[7:0];
    end
  end

endmodule

// File: rtl/layer_motion_updater.sv
// rtl/layer_motion_updater.sv - frame-start walker that advances sprite position and animation per layer
// Optional LAYER_MOTION_CLAMP_EN (in layer_motion_calc) saturates position updates.
import gpu_layer_pkg::*;

module layer_motion_updater #(
  parameter int NUM_LAYERS = 32,
  parameter int VEL_SHIFT  = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  output logic [4:0]  ctrl_layer,
  output logic [2:0]  reg_index,
  output logic [15:0] write_data,
  output logic        write_en,
  input  logic [15:0] read_data,
  output logic        busy,
  output logic        done,
  output logic        frame_overrun
);

  motionStateT state, nextState;
  logic [4:0]  layerCnt, nextLayer;
  logic        animQ;
  logic [15:0] xposQ, yposQ, xvelQ, yvelQ, frameQ;

  logic [2:0]  nRegIndex;
  logic [15:0] nWriteData;
  logic        nWriteEn, nBusy, nDone;
  logic        lastLayer, isSprite, selX;
  logic [15:0] calcPos;
  logic [7:0]  calcFrame;

  assign lastLayer = (layerCnt == 5'(NUM_LAYERS - 1));
  assign isSprite  = read_data[FLAG_POP] & read_data[FLAG_SPRITE];
  // X operands feed the calc on the way into WR_XPOS, Y operands otherwise
  assign selX      = (state == ST_RD_FRAME);

  layer_motion_calc #(.VEL_SHIFT(VEL_SHIFT)) calc (
    .pos       (selX ? xposQ : yposQ),
    .vel       (selX ? xvelQ : yvelQ),
    .cur       (frameQ[15:8]),
    .count     (frameQ[7:0]),
    .animEn    (animQ),
    .newPos    (calcPos),
    .nextFrame (calcFrame)
  );

  always_comb begin
    nextState = state;
    nextLayer = layerCnt;
    case (state)
      ST_IDLE: begin
        if (frame_start) begin
          nextState = ST_RD_FLAGS;
          nextLayer = 5'd0;
        end
      end
      ST_RD_FLAGS: begin
        if (isSprite) begin
          nextState = ST_RD_XPOS;
        end else if (lastLayer) begin
          nextState = ST_DONE;
        end else begin
          nextLayer = layerCnt + 5'd1;
        end
      end
      ST_RD_XPOS:  nextState = ST_RD_YPOS;
      ST_RD_YPOS:  nextState = ST_RD_XVEL;
      ST_RD_XVEL:  nextState = ST_RD_YVEL;
      ST_RD_YVEL:  nextState = ST_RD_FRAME;
      ST_RD_FRAME: nextState = ST_WR_XPOS;
      ST_WR_XPOS:  nextState = ST_WR_YPOS;
      ST_WR_YPOS:  nextState = ST_WR_FRAME;
      ST_WR_FRAME: begin
        if (lastLayer) begin
          nextState = ST_DONE;
        end else begin
          nextState = ST_RD_FLAGS;
          nextLayer = layerCnt + 5'd1;
        end
      end
      ST_DONE:     nextState = ST_IDLE;
      default:     nextState = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they can be registered alongside it
  always_comb begin
    nRegIndex  = REG_FLAGS;
    nWriteData = 16'h0000;
    nWriteEn   = 1'b0;
    nBusy      = 1'b1;
    nDone      = 1'b0;
    case (nextState)
      ST_RD_FLAGS: nRegIndex = REG_FLAGS;
      ST_RD_XPOS:  nRegIndex = REG_XPOS;
      ST_RD_YPOS:  nRegIndex = REG_YPOS;
      ST_RD_XVEL:  nRegIndex = REG_XVEL;
      ST_RD_YVEL:  nRegIndex = REG_YVEL;
      ST_RD_FRAME: nRegIndex = REG_FRAME;
      ST_WR_XPOS: begin
        nRegIndex  = REG_XPOS;
        nWriteEn   = 1'b1;
        nWriteData = calcPos;
      end
      ST_WR_YPOS: begin
        nRegIndex  = REG_YPOS;
        nWriteEn   = 1'b1;
        nWriteData = calcPos;
      end
      ST_WR_FRAME: begin
        nRegIndex  = REG_FRAME;
        nWriteEn   = 1'b1;
        nWriteData = {calcFrame, frameQ[7:0]};
      end
      ST_DONE: begin
        nBusy = 1'b0;
        nDone = 1'b1;
      end
      default: nBusy = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      layerCnt      <= 5'd0;
      animQ         <= 1'b0;
      xposQ         <= 16'h0000;
      yposQ         <= 16'h0000;
      xvelQ         <= 16'h0000;
      yvelQ         <= 16'h0000;
      frameQ        <= 16'h0000;
      ctrl_layer    <= 5'd0;
      reg_index     <= 3'd0;
      write_data    <= 16'h0000;
      write_en      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      frame_overrun <= 1'b0;
    end else begin
      state         <= nextState;
      layerCnt      <= nextLayer;
      ctrl_layer    <= nBusy ? nextLayer : 5'd0;
      reg_index     <= nRegIndex;
      write_data    <= nWriteData;
      write_en      <= nWriteEn;
      busy          <= nBusy;
      done          <= nDone;
      frame_overrun <= frame_start && (state != ST_IDLE);
      case (state)
        ST_RD_FLAGS: animQ  <= read_data[FLAG_ANIM];
        ST_RD_XPOS:  xposQ  <= read_data;
        ST_RD_YPOS:  yposQ  <= read_data;
        ST_RD_XVEL:  xvelQ  <= read_data;
        ST_RD_YVEL:  yvelQ  <= read_data;
        ST_RD_FRAME: frameQ <= read_data;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_motion_updater.sv
// tb/tb_layer_motion_updater.sv - randomized and directed check of layer_motion_updater against a bus-trace model
`timescale 1ns/1ps
module tb_layer_motion_updater;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic [4:0]  ctrl_layer;
  logic [2:0]  reg_index;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        write_en, busy, done, frame_overrun;

  logic [15:0] hdr    [32][8];
  logic [15:0] expMem [32][8];

  typedef struct {
    int          layer;
    int          regIdx;
    bit          we;
    logic [15:0] data;
    bit          isDone;
  } opT;

  opT expQ[$];
  opT curOp;
  int total = 0;
  int bad = 0;
  bit checkOn = 1'b0;
  bit pendOv = 1'b0;

  always #5 clk = ~clk;

  layer_motion_updater dut (
    .clk           (clk),
    .reset         (reset),
    .frame_start   (frame_start),
    .ctrl_layer    (ctrl_layer),
    .reg_index     (reg_index),
    .write_data    (write_data),
    .write_en      (write_en),
    .read_data     (read_data),
    .busy          (busy),
    .done          (done),
    .frame_overrun (frame_overrun)
  );

  assign read_data = hdr[ctrl_layer][reg_index];

  always @(negedge clk) begin
    if (write_en === 1'b1) hdr[ctrl_layer][reg_index] = write_data;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] stepPos(input logic [15:0] pos, input logic [15:0] vel);
    int p, v, s;
    p = $signed(pos);
    v = $signed(vel);
    s = p + (v >>> 6);
`ifdef LAYER_MOTION_CLAMP_EN
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`endif
    return 16'(s);
  endfunction

  function automatic logic [7:0] stepFrame(input bit anim, input int cur, input int cnt);
    if (!anim || cnt == 0) return 8'(cur);
    if (cur + 1 >= cnt) return 8'd0;
    return 8'(cur + 1);
  endfunction

  // Expected bus trace of one walk, one entry per cycle, plus the resulting header contents
  task automatic buildModel();
    logic [15:0] f, nx, ny;
    logic [7:0]  nf;
    expQ.delete();
    for (int l = 0; l < 32; l++)
      for (int r = 0; r < 8; r++) expMem[l][r] = hdr[l][r];
    for (int l = 0; l < 32; l++) begin
      expQ.push_back('{l, 0, 1'b0, 16'h0, 1'b0});
      f = expMem[l][0];
      if (f[0] && f[1]) begin
        for (int r = 3; r <= 7; r++) expQ.push_back('{l, r, 1'b0, 16'h0, 1'b0});
        nx = stepPos(expMem[l][3], expMem[l][5]);
        ny = stepPos(expMem[l][4], expMem[l][6]);
        nf = stepFrame(f[3], int'(expMem[l][7][15:8]), int'(expMem[l][7][7:0]));
        expQ.push_back('{l, 3, 1'b1, nx, 1'b0});
        expQ.push_back('{l, 4, 1'b1, ny, 1'b0});
        expQ.push_back('{l, 7, 1'b1, {nf, expMem[l][7][7:0]}, 1'b0});
        expMem[l][3] = nx;
        expMem[l][4] = ny;
        expMem[l][7] = {nf, expMem[l][7][7:0]};
      end
    end
    expQ.push_back('{0, 0, 1'b0, 16'h0, 1'b1});
  endtask

  always @(negedge clk) begin
    if (!checkOn) begin
      pendOv = 1'b0;
    end else begin
      chk("frame_overrun", frame_overrun, pendOv);
      if (expQ.size() > 0) begin
        curOp = expQ.pop_front();
        if (curOp.isDone) begin
          chk("done_cycle.done", done, 1);
          chk("done_cycle.busy", busy, 0);
          chk("done_cycle.write_en", write_en, 0);
        end else begin
          chk("walk.busy", busy, 1);
          chk("walk.done", done, 0);
          chk("walk.ctrl_layer", ctrl_layer, curOp.layer);
          chk("walk.reg_index", reg_index, curOp.regIdx);
          chk("walk.write_en", write_en, curOp.we);
          if (curOp.we) chk("walk.write_data", write_data, curOp.data);
        end
        pendOv = frame_start;
      end else begin
        chk("idle.busy", busy, 0);
        chk("idle.done", done, 0);
        chk("idle.write_en", write_en, 0);
        pendOv = 1'b0;
      end
    end
  end

  task automatic clrHdr();
    for (int l = 0; l < 32; l++)
      for (int r = 0; r < 8; r++) hdr[l][r] = 16'h0000;
  endtask

  task automatic randHdr();
    for (int l = 0; l < 32; l++) begin
      hdr[l][0] = 16'($urandom_range(0, 15));
      for (int r = 1; r < 7; r++) hdr[l][r] = 16'($urandom);
      hdr[l][7] = {8'($urandom_range(0, 6)), 8'($urandom_range(0, 5))};
    end
  endtask

  task automatic startFrame();
    @(posedge clk);
    #2 frame_start = 1'b1;
    @(posedge clk);
    #2 frame_start = 1'b0;
    buildModel();
  endtask

  task automatic runFrame(input int repulseAt, output int latency, output int wrCnt,
                          output int ovCnt, output int doneCnt, output int firstOp);
    int c;
    latency = -1;
    wrCnt = 0;
    ovCnt = 0;
    doneCnt = 0;
    startFrame();
    firstOp = {ctrl_layer, reg_index};
    c = 1;
    while (c < 600) begin
      if (write_en) wrCnt++;
      if (frame_overrun) ovCnt++;
      if (done) begin
        doneCnt++;
        latency = c;
        break;
      end
      frame_start = (c == repulseAt);
      @(posedge clk);
      #2 c++;
    end
    frame_start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #2;
      if (done) doneCnt++;
      if (frame_overrun) ovCnt++;
    end
    chk("model_drained", expQ.size(), 0);
  endtask

  task automatic checkMem(input string nm);
    int errs;
    errs = 0;
    for (int l = 0; l < 32; l++)
      for (int r = 0; r < 8; r++)
        if (hdr[l][r] !== expMem[l][r]) errs++;
    chk(nm, errs, 0);
  endtask

  initial begin
    int lat, wr, ov, dn, first;
    bit found;
    clrHdr();
    repeat (3) @(posedge clk);
    #2;
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
    chk("reset.write_en", write_en, 0);
    chk("reset.ctrl_layer", ctrl_layer, 0);
    chk("reset.reg_index", reg_index, 0);
    chk("reset.write_data", write_data, 0);
    chk("reset.frame_overrun", frame_overrun, 0);
    reset = 1'b0;
    @(posedge clk);
    #2 checkOn = 1'b1;

    // all layers empty
    runFrame(0, lat, wr, ov, dn, first);
    chk("empty.latency", lat, 33);
    chk("empty.writes", wr, 0);
    chk("empty.done_pulses", dn, 1);

    // single sprite on layer 5
    clrHdr();
    hdr[5][0] = 16'h000B;
    hdr[5][3] = 16'd100;
    hdr[5][4] = 16'hFFEC;
    hdr[5][5] = 16'd640;
    hdr[5][6] = 16'hFF80;
    hdr[5][7] = 16'h0203;
    runFrame(0, lat, wr, ov, dn, first);
    chk("l5.latency", lat, 41);
    chk("l5.xpos", hdr[5][3], 16'd110);
    chk("l5.ypos", hdr[5][4], 16'hFFEA);
    chk("l5.frame", hdr[5][7], 16'h0003);
    checkMem("l5.mem");

    // text layer skipped, hidden sprite updated without animation
    clrHdr();
    hdr[2][0] = 16'h0001;
    hdr[2][3] = 16'd55;
    hdr[3][0] = 16'h0007;
    hdr[3][5] = 16'd64;
    hdr[3][7] = 16'h0102;
    runFrame(0, lat, wr, ov, dn, first);
    chk("l3.xpos", hdr[3][3], 16'd1);
    chk("l3.frame", hdr[3][7], 16'h0102);
    chk("l2.xpos_untouched", hdr[2][3], 16'd55);
    chk("l23.writes", wr, 3);

    // position overflow on layer 0
    clrHdr();
    hdr[0][0] = 16'h0003;
    hdr[0][3] = 16'd32760;
    hdr[0][5] = 16'd1024;
    runFrame(0, lat, wr, ov, dn, first);
`ifdef LAYER_MOTION_CLAMP_EN
    chk("l0.xpos_overflow", hdr[0][3], 16'h7FFF);
`else
    chk("l0.xpos_overflow", hdr[0][3], 16'h8008);
`endif

    // randomized frames, state carried across frames
    randHdr();
    for (int i = 0; i < 6; i++) begin
      runFrame(0, lat, wr, ov, dn, first);
      checkMem("rand.mem");
      chk("rand.done_pulses", dn, 1);
    end

    // frame_start re-pulsed mid-walk
    randHdr();
    runFrame(10, lat, wr, ov, dn, first);
    chk("repulse.overruns", ov, 1);
    chk("repulse.done_pulses", dn, 1);
    checkMem("repulse.mem");

    // reset during WR_YPOS of layer 7, then restart
    randHdr();
    hdr[7][0] = 16'h0003;
    startFrame();
    found = 1'b0;
    for (int c = 0; c < 600 && !found; c++) begin
      if (ctrl_layer == 5'd7 && reg_index == 3'd4 && write_en) found = 1'b1;
      else begin
        @(posedge clk);
        #2;
      end
    end
    chk("abort.reached_wr_ypos", found, 1);
    reset = 1'b1;
    checkOn = 1'b0;
    expQ.delete();
    @(posedge clk);
    #2;
    chk("abort.busy", busy, 0);
    chk("abort.write_en", write_en, 0);
    reset = 1'b0;
    @(posedge clk);
    #2 checkOn = 1'b1;
    runFrame(0, lat, wr, ov, dn, first);
    chk("restart.first_op", first, 0);
    chk("restart.done_pulses", dn, 1);
    checkMem("restart.mem");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
